// File: rtl/hwag_ign_sched.sv
// Angle-driven ignition scheduler. Each channel dwells the coil between a
// programmable dwell-start angle and spark angle of the 720-degree engine cycle.
// Configuration is double-buffered: writes land in shadow registers, and a
// commit copies shadow->active only at the cycle wrap (or while the angle
// generator is not synchronised), so a channel never sees a half-updated pair.
module hwag_ign_sched #(
  parameter int NCH       = 4,
  parameter int ANGLE_W   = 13,
  parameter int CYCLE_TOP = 7679,
  parameter int TMO_W     = 24,
  parameter int DWELL_TMO = 2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hwag_start,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               angle_step,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2:0]         cfg_ch,
  input  logic [1:0]         cfg_sel,
  input  logic [ANGLE_W-1:0] cfg_data,
  input  logic               cfg_commit,
  output logic               commit_pending,
  output logic               cfg_err,
  output logic [NCH-1:0]     ign_out,
  output logic [NCH-1:0]     tmo_flag
);

  typedef enum logic [1:0] {ST_OFF, ST_ARMED, ST_DWELL} ch_state_t;

  logic commit_pending_reg;
  logic cfg_err_reg;
  logic wr_acc;
  logic angle_bad;
  logic commit_now;

  // Writes are refused while a commit is outstanding so the shadow set that
  // will be copied cannot change underneath it.
  assign wr_acc     = cfg_valid & ~commit_pending_reg;
  assign angle_bad  = cfg_data > ANGLE_W'(CYCLE_TOP);
  assign commit_now = commit_pending_reg & ((angle_step & (angle == '0)) | ~hwag_start);

  assign cfg_ready      = ~commit_pending_reg;
  assign commit_pending = commit_pending_reg;
  assign cfg_err        = cfg_err_reg;

  // Commit request tracking and out-of-range write error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pending_reg <= 1'b0;
      cfg_err_reg        <= 1'b0;
    end else begin
      if (commit_now)
        commit_pending_reg <= 1'b0;
      else if (cfg_commit)
        commit_pending_reg <= 1'b1;
      cfg_err_reg <= wr_acc & ~cfg_sel[1] & angle_bad;
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [ANGLE_W-1:0] dwell_sh_reg, spark_sh_reg;
      logic [ANGLE_W-1:0] dwell_act_reg, spark_act_reg;
      logic               en_sh_reg, en_act_reg;
      logic [ANGLE_W-1:0] spark_lock_reg;
      logic [TMO_W-1:0]   tmo_cnt_reg;
      logic               tmo_flag_reg;
      ch_state_t          state_reg, state_next;
      logic               ch_hit;
      logic               cfg_ok;
      logic               spark_hit;
      logic               tmo_hit;
      logic               tmo_fire;

      assign ch_hit    = wr_acc & (cfg_ch == 3'(gi));
      assign cfg_ok    = en_act_reg & (dwell_act_reg != spark_act_reg);
      assign spark_hit = angle_step & (angle == spark_lock_reg);
      assign tmo_hit   = tmo_cnt_reg == TMO_W'(DWELL_TMO - 1);

      // Shadow register writes; out-of-range angles are discarded.
      always_ff @(posedge clk) begin
        if (rst) begin
          dwell_sh_reg <= '0;
          spark_sh_reg <= '0;
          en_sh_reg    <= 1'b0;
        end else if (ch_hit) begin
          case (cfg_sel)
            2'd0: if (!angle_bad) dwell_sh_reg <= cfg_data;
            2'd1: if (!angle_bad) spark_sh_reg <= cfg_data;
            2'd2: en_sh_reg <= cfg_data[0];
            default: ;
          endcase
        end
      end

      // Atomic shadow->active transfer.
      always_ff @(posedge clk) begin
        if (rst) begin
          dwell_act_reg <= '0;
          spark_act_reg <= '0;
          en_act_reg    <= 1'b0;
        end else if (commit_now) begin
          dwell_act_reg <= dwell_sh_reg;
          spark_act_reg <= spark_sh_reg;
          en_act_reg    <= en_sh_reg;
        end
      end

      // Channel FSM next-state: loss of sync or disable wins over everything.
      always_comb begin
        state_next = state_reg;
        tmo_fire   = 1'b0;
        if (!hwag_start || !en_act_reg) begin
          state_next = ST_OFF;
        end else begin
          case (state_reg)
            ST_OFF:   if (cfg_ok) state_next = ST_ARMED;
            ST_ARMED: begin
              if (!cfg_ok)
                state_next = ST_OFF;
              else if (angle_step && (angle == dwell_act_reg))
                state_next = ST_DWELL;
            end
            ST_DWELL: begin
              if (spark_hit) begin
                state_next = ST_ARMED;
              end else if (tmo_hit) begin
                state_next = ST_ARMED;
                tmo_fire   = 1'b1;
              end
            end
            default: state_next = ST_OFF;
          endcase
        end
      end

      // Channel FSM state register.
      always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_OFF;
        else     state_reg <= state_next;
      end

      // Spark angle is frozen at dwell start so a mid-dwell commit cannot move it.
      always_ff @(posedge clk) begin
        if (rst) begin
          spark_lock_reg <= '0;
          tmo_cnt_reg    <= '0;
        end else if (state_reg != ST_DWELL && state_next == ST_DWELL) begin
          spark_lock_reg <= spark_act_reg;
          tmo_cnt_reg    <= '0;
        end else if (state_reg == ST_DWELL && tmo_cnt_reg != '1) begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
      end

      // Sticky timeout flag, cleared by re-enabling the channel.
      always_ff @(posedge clk) begin
        if (rst)
          tmo_flag_reg <= 1'b0;
        else if (tmo_fire)
          tmo_flag_reg <= 1'b1;
        else if (ch_hit && cfg_sel == 2'd2 && cfg_data[0])
          tmo_flag_reg <= 1'b0;
      end

      assign ign_out[gi]  = (state_reg == ST_DWELL);
      assign tmo_flag[gi] = tmo_flag_reg;
    end
  endgenerate

endmodule

// File: tb/tb_hwag_ign_sched.sv
// Bench for hwag_ign_sched: directed scenarios plus a randomized run, all
// compared against a cycle-level behavioural model of the channel rules.
module tb_hwag_ign_sched;
  localparam int NCH       = 4;
  localparam int ANGLE_W   = 13;
  localparam int CYCLE_TOP = 7679;
  localparam int TMO_W     = 24;
  localparam int DWELL_TMO = 400;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               hwag_start = 1'b0;
  logic [ANGLE_W-1:0] angle = '0;
  logic               angle_step = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [2:0]         cfg_ch = '0;
  logic [1:0]         cfg_sel = '0;
  logic [ANGLE_W-1:0] cfg_data = '0;
  logic               cfg_commit = 1'b0;
  logic               commit_pending;
  logic               cfg_err;
  logic [NCH-1:0]     ign_out;
  logic [NCH-1:0]     tmo_flag;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hwag_ign_sched #(
    .NCH(NCH), .ANGLE_W(ANGLE_W), .CYCLE_TOP(CYCLE_TOP),
    .TMO_W(TMO_W), .DWELL_TMO(DWELL_TMO)
  ) dut (
    .clk(clk), .rst(rst), .hwag_start(hwag_start), .angle(angle),
    .angle_step(angle_step), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .commit_pending(commit_pending),
    .cfg_err(cfg_err), .ign_out(ign_out), .tmo_flag(tmo_flag)
  );

  // Reference model: per channel, "waiting" for the dwell angle or "dwelling"
  // with an age in clocks; shadow/active angle sets as plain integers.
  int sh_d[NCH], sh_s[NCH], ac_d[NCH], ac_s[NCH];
  bit sh_e[NCH], ac_e[NCH];
  bit m_wait[NCH], m_dw[NCH], m_tmo[NCH];
  int m_lock[NCH], m_age[NCH];
  bit m_pend, m_err;

  function automatic logic [NCH-1:0] exp_ign();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_dw[i];
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_tmo();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_tmo[i];
    return v;
  endfunction

  // Advance the model with the inputs presented this cycle, then clock the DUT.
  task automatic tick();
    bit acc;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        sh_d[i] = 0; sh_s[i] = 0; ac_d[i] = 0; ac_s[i] = 0;
        sh_e[i] = 0; ac_e[i] = 0; m_wait[i] = 0; m_dw[i] = 0;
        m_tmo[i] = 0; m_lock[i] = 0; m_age[i] = 0;
      end
      m_pend = 0; m_err = 0;
    end else begin
      acc = cfg_valid && !m_pend;
      for (int i = 0; i < NCH; i++) begin
        if (acc && cfg_sel == 2 && cfg_ch == i && cfg_data[0]) m_tmo[i] = 0;
        if (!hwag_start || !ac_e[i]) begin
          m_wait[i] = 0; m_dw[i] = 0;
        end else if (m_dw[i]) begin
          if (angle_step && angle == m_lock[i]) begin
            m_dw[i] = 0; m_wait[i] = 1;
          end else if (m_age[i] + 1 >= DWELL_TMO) begin
            m_dw[i] = 0; m_wait[i] = 1; m_tmo[i] = 1;
          end else begin
            m_age[i]++;
          end
        end else if (m_wait[i]) begin
          if (ac_d[i] == ac_s[i]) m_wait[i] = 0;
          else if (angle_step && angle == ac_d[i]) begin
            m_wait[i] = 0; m_dw[i] = 1; m_lock[i] = ac_s[i]; m_age[i] = 0;
          end
        end else if (ac_d[i] != ac_s[i]) begin
          m_wait[i] = 1;
        end
      end
      if (m_pend && ((angle_step && angle == 0) || !hwag_start)) begin
        for (int i = 0; i < NCH; i++) begin
          ac_d[i] = sh_d[i]; ac_s[i] = sh_s[i]; ac_e[i] = sh_e[i];
        end
        m_pend = 0;
      end else if (cfg_commit) begin
        m_pend = 1;
      end
      m_err = acc && cfg_sel < 2 && cfg_data > CYCLE_TOP;
      if (acc && cfg_ch < NCH) begin
        if (cfg_sel == 0 && cfg_data <= CYCLE_TOP) sh_d[cfg_ch] = int'(cfg_data);
        if (cfg_sel == 1 && cfg_data <= CYCLE_TOP) sh_s[cfg_ch] = int'(cfg_data);
        if (cfg_sel == 2) sh_e[cfg_ch] = cfg_data[0];
      end
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0; cfg_commit = 1'b0; angle_step = 1'b0;
  endtask

  task automatic do_step();
    angle = (angle == ANGLE_W'(CYCLE_TOP)) ? '0 : angle + 1'b1;
    angle_step = 1'b1;
    tick();
  endtask

  task automatic cfg_write(input int ch, input int sel, input int data);
    cfg_valid = 1'b1; cfg_ch = 3'(ch); cfg_sel = 2'(sel); cfg_data = ANGLE_W'(data);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_total++; if (ign_out !== '0) $display("FAIL reset_ign got=%b want=0", ign_out); else n_pass++;
    n_total++; if (tmo_flag !== '0) $display("FAIL reset_tmo got=%b want=0", tmo_flag); else n_pass++;
    n_total++; if (commit_pending !== 1'b0) $display("FAIL reset_pending got=%b want=0", commit_pending); else n_pass++;
    n_total++; if (cfg_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", cfg_ready); else n_pass++;
    n_total++; if (cfg_err !== 1'b0) $display("FAIL reset_err got=%b want=0", cfg_err); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    hwag_start = 1'b0; angle = '0;
    cfg_write(0, 0, 100); cfg_write(0, 1, 228); cfg_write(0, 2, 1);
    cfg_write(1, 0, 600); cfg_write(1, 1, 700); cfg_write(1, 2, 1);
    cfg_commit = 1'b1; tick();
    n_total++; if (commit_pending !== 1'b1) $display("FAIL basic_pending_set got=%b want=1", commit_pending); else n_pass++;
    tick();
    n_total++; if (commit_pending !== 1'b0) $display("FAIL basic_pending_clr got=%b want=0", commit_pending); else n_pass++;
    hwag_start = 1'b1; tick();
    for (int a = 1; a <= 300; a++) begin
      do_step();
      n_total++;
      if (ign_out[0] !== (a >= 100 && a < 228))
        $display("FAIL basic_ign0 angle=%0d got=%b want=%b", a, ign_out[0], (a >= 100 && a < 228));
      else n_pass++;
      n_total++; if (ign_out !== exp_ign()) $display("FAIL basic_model angle=%0d got=%b want=%b", a, ign_out, exp_ign()); else n_pass++;
    end
  endtask

  task automatic test_pending();
    while (angle != 500) do_step();
    cfg_write(1, 1, 900);
    cfg_commit = 1'b1; tick();
    n_total++; if (commit_pending !== 1'b1 || cfg_ready !== 1'b0)
      $display("FAIL pend_set got=%b/%b want=1/0", commit_pending, cfg_ready); else n_pass++;
    cfg_write(1, 0, 650);
    while (angle != ANGLE_W'(CYCLE_TOP)) begin
      do_step();
      n_total++;
      if (commit_pending !== 1'b1 || cfg_ready !== 1'b0 || ign_out[1] !== (angle >= 600 && angle < 700))
        $display("FAIL pend_hold angle=%0d got=%b/%b/%b want=1/0/%b", angle, commit_pending, cfg_ready,
                 ign_out[1], (angle >= 600 && angle < 700));
      else n_pass++;
    end
    do_step();
    n_total++; if (commit_pending !== 1'b0 || cfg_ready !== 1'b1)
      $display("FAIL pend_wrap got=%b/%b want=0/1", commit_pending, cfg_ready); else n_pass++;
    for (int a = 1; a <= 1000; a++) begin
      do_step();
      n_total++;
      if (ign_out[1] !== (a >= 600 && a < 900))
        $display("FAIL pend_newspark angle=%0d got=%b want=%b", a, ign_out[1], (a >= 600 && a < 900));
      else n_pass++;
      n_total++; if (ign_out !== exp_ign()) $display("FAIL pend_model angle=%0d got=%b want=%b", a, ign_out, exp_ign()); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    cfg_write(2, 0, 7600); cfg_write(2, 1, 40); cfg_write(2, 2, 1);
    cfg_commit = 1'b1; tick();
    hwag_start = 1'b0; tick();
    n_total++; if (commit_pending !== 1'b0) $display("FAIL wrap_commit got=%b want=0", commit_pending); else n_pass++;
    angle = ANGLE_W'(7550); hwag_start = 1'b1; tick();
    for (int i = 0; i < 230; i++) begin
      do_step();
      n_total++;
      if (ign_out[2] !== (angle >= 7600 || angle < 40))
        $display("FAIL wrap_ign2 angle=%0d got=%b want=%b", angle, ign_out[2], (angle >= 7600 || angle < 40));
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    hwag_start = 1'b0; tick();
    cfg_write(3, 0, 10); cfg_write(3, 1, 20); cfg_write(3, 2, 1);
    cfg_commit = 1'b1; tick(); tick();
    angle = '0; hwag_start = 1'b1; tick();
    for (int a = 1; a <= 15; a++) begin
      do_step();
      n_total++; if (ign_out[3] !== (a >= 10)) $display("FAIL tmo_rise angle=%0d got=%b want=%b", a, ign_out[3], (a >= 10)); else n_pass++;
    end
    for (int k = 6; k <= DWELL_TMO + 5; k++) begin
      tick();
      n_total++; if (ign_out[3] !== (k < DWELL_TMO)) $display("FAIL tmo_fall clk=%0d got=%b want=%b", k, ign_out[3], (k < DWELL_TMO)); else n_pass++;
    end
    n_total++; if (tmo_flag[3] !== 1'b1) $display("FAIL tmo_flag_set got=%b want=1", tmo_flag[3]); else n_pass++;
    n_total++; if (tmo_flag !== exp_tmo()) $display("FAIL tmo_model got=%b want=%b", tmo_flag, exp_tmo()); else n_pass++;
    cfg_write(3, 2, 1);
    n_total++; if (tmo_flag[3] !== 1'b0) $display("FAIL tmo_flag_clr got=%b want=0", tmo_flag[3]); else n_pass++;
  endtask

  task automatic test_drop();
    hwag_start = 1'b0; angle = ANGLE_W'(90); tick();
    hwag_start = 1'b1; tick();
    while (angle != 150) do_step();
    n_total++; if (ign_out[0] !== 1'b1) $display("FAIL drop_dwell got=%b want=1", ign_out[0]); else n_pass++;
    hwag_start = 1'b0; tick();
    n_total++; if (ign_out[0] !== 1'b0) $display("FAIL drop_off got=%b want=0", ign_out[0]); else n_pass++;
    angle = ANGLE_W'(90); hwag_start = 1'b1; tick();
    while (angle != 101) do_step();
    n_total++; if (ign_out[0] !== 1'b1) $display("FAIL drop_rearm got=%b want=1", ign_out[0]); else n_pass++;
  endtask

  task automatic test_err();
    cfg_write(0, 0, 8000);
    n_total++; if (cfg_err !== 1'b1) $display("FAIL err_pulse got=%b want=1", cfg_err); else n_pass++;
    tick();
    n_total++; if (cfg_err !== 1'b0) $display("FAIL err_clear got=%b want=0", cfg_err); else n_pass++;
    cfg_write(1, 0, 300); cfg_write(1, 1, 300);
    hwag_start = 1'b0; cfg_commit = 1'b1; tick(); tick();
    angle = ANGLE_W'(90); hwag_start = 1'b1; tick();
    for (int a = 91; a <= 400; a++) begin
      do_step();
      n_total++;
      if (ign_out[0] !== (a >= 100 && a < 228) || ign_out[1] !== 1'b0)
        $display("FAIL err_shadow angle=%0d got=%b%b want=0%b", a, ign_out[1], ign_out[0], (a >= 100 && a < 228));
      else n_pass++;
    end
  endtask

  task automatic test_rst_mid();
    hwag_start = 1'b0; angle = ANGLE_W'(90); tick();
    hwag_start = 1'b1; tick();
    while (angle != 120) do_step();
    n_total++; if (ign_out[0] !== 1'b1) $display("FAIL rstmid_dwell got=%b want=1", ign_out[0]); else n_pass++;
    rst = 1'b1; tick();
    n_total++; if (ign_out !== '0 || tmo_flag !== '0) $display("FAIL rstmid_out got=%b/%b want=0/0", ign_out, tmo_flag); else n_pass++;
    rst = 1'b0; tick();
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 6000; it++) begin
      if (!hwag_start) begin
        if ($urandom_range(0, 3) == 0) begin
          angle = ($urandom_range(0, 1) == 0) ? ANGLE_W'($urandom_range(0, 400))
                                              : ANGLE_W'($urandom_range(7600, CYCLE_TOP));
          hwag_start = 1'b1;
        end
      end else if ($urandom_range(0, 299) == 0) begin
        hwag_start = 1'b0;
      end else if ($urandom_range(0, 3) != 0) begin
        angle = (angle == ANGLE_W'(CYCLE_TOP)) ? '0 : angle + 1'b1;
        angle_step = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch = 3'($urandom_range(0, NCH));
        cfg_sel = 2'($urandom_range(0, 3));
        r = $urandom_range(0, 9);
        if (r < 5)      cfg_data = ANGLE_W'($urandom_range(0, 500));
        else if (r < 7) cfg_data = ANGLE_W'($urandom_range(7600, CYCLE_TOP));
        else if (r < 8) cfg_data = ANGLE_W'($urandom_range(CYCLE_TOP + 1, 8191));
        else            cfg_data = ANGLE_W'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 24) == 0) cfg_commit = 1'b1;
      tick();
      n_total++;
      if (ign_out !== exp_ign() || tmo_flag !== exp_tmo() || commit_pending !== m_pend ||
          cfg_ready !== !m_pend || cfg_err !== m_err)
        $display("FAIL rand it=%0d angle=%0d got ign=%b tmo=%b pend=%b rdy=%b err=%b want ign=%b tmo=%b pend=%b rdy=%b err=%b",
                 it, angle, ign_out, tmo_flag, commit_pending, cfg_ready, cfg_err,
                 exp_ign(), exp_tmo(), m_pend, !m_pend, m_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pending();
    test_wrap();
    test_timeout();
    test_drop();
    test_err();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
